// File: rtl/clint_irq_ctrl_if.sv
// Bus port of the core-local interruptor: single-outstanding request and
// response channels with valid/ready handshakes.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_addr            : byte offset, bits [15:3] decoded
//   req_wen             : 1 = write, 0 = read
//   req_wdata/req_wmask : write data and byte enables
//   resp_valid/resp_ready: response handshake
//   resp_rdata/resp_err : read data (0 for writes), unmapped-offset flag
interface clint_irq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/clint_irq_ctrl.sv
// Core-local interruptor: memory-mapped msip / mtimecmp / mtime registers
// behind a single-outstanding bus port, driving the timer and software
// interrupt inputs of the CSR block.
//   clock           : rising-edge clock
//   reset           : asynchronous active-low reset
//   io              : bus port (slave side)
//   io_csr_mstatus  : CSR mstatus, bit 3 = MIE
//   io_csr_mie      : CSR mie, bit 7 = MTIE, bit 3 = MSIE
//   io_time_irq     : timer interrupt request to the CSR block
//   io_soft_irq     : software interrupt request to the CSR block
//   io_mtime        : current mtime value
module clint_irq_ctrl #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clock,
  input  logic             reset,
  clint_irq_ctrl_if.slave  io,
  input  logic [63:0]      io_csr_mstatus,
  input  logic [63:0]      io_csr_mie,
  output logic             io_time_irq,
  output logic             io_soft_irq,
  output logic [63:0]      io_mtime
);

  localparam logic [15:0] DIV_LAST   = 16'(TICK_DIV - 1);
  localparam logic [12:0] A_MSIP     = 13'h0000;
  localparam logic [12:0] A_MTIMECMP = 13'h0800;
  localparam logic [12:0] A_MTIME    = 13'h17FF;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] div_cnt_q;
  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        msip_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        tick;
  logic [12:0] sel;
  logic        hit_msip, hit_cmp, hit_time, hit_any;
  logic [63:0] mask64;
  logic [63:0] rd_val;
  logic        wr_msip, wr_cmp, wr_time;
  logic        unused_bits;

  // Bus FSM: IDLE accepts one request, RESP holds the registered response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    io.req_ready  = 1'b0;
    io.resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) state_d = S_RESP;
      end
      S_RESP: begin
        io.resp_valid = 1'b1;
        if (io.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = io.req_valid & io.req_ready;
  assign tick   = (div_cnt_q == DIV_LAST);
  assign sel    = io.req_addr[15:3];

  assign hit_msip = (sel == A_MSIP);
  assign hit_cmp  = (sel == A_MTIMECMP);
  assign hit_time = (sel == A_MTIME);
  assign hit_any  = hit_msip | hit_cmp | hit_time;

  assign mask64 = {{8{io.req_wmask[7]}}, {8{io.req_wmask[6]}},
                   {8{io.req_wmask[5]}}, {8{io.req_wmask[4]}},
                   {8{io.req_wmask[3]}}, {8{io.req_wmask[2]}},
                   {8{io.req_wmask[1]}}, {8{io.req_wmask[0]}}};

  assign wr_msip = accept & io.req_wen & hit_msip;
  assign wr_cmp  = accept & io.req_wen & hit_cmp;
  assign wr_time = accept & io.req_wen & hit_time;

  always_comb begin
    rd_val = '0;
    if (hit_msip)      rd_val = {63'd0, msip_q};
    else if (hit_cmp)  rd_val = mtimecmp_q;
    else if (hit_time) rd_val = mtime_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_q  <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 16'd1;

      // A bus write wins over a coincident tick; that increment is lost.
      if (wr_time)
        mtime_q <= (mtime_q & ~mask64) | (io.req_wdata & mask64);
      else if (tick)
        mtime_q <= mtime_q + 64'd1;

      if (wr_cmp)
        mtimecmp_q <= (mtimecmp_q & ~mask64) | (io.req_wdata & mask64);

      if (wr_msip)
        msip_q <= (msip_q & ~mask64[0]) | (io.req_wdata[0] & mask64[0]);

      // Response captured at the accept edge from pre-update register values.
      if (accept) begin
        rdata_q <= io.req_wen ? '0 : rd_val;
        err_q   <= ~hit_any;
      end
    end
  end

  assign io.resp_rdata = rdata_q;
  assign io.resp_err   = err_q;
  assign io_mtime      = mtime_q;

  assign io_time_irq = (mtime_q >= mtimecmp_q) & io_csr_mstatus[3] & io_csr_mie[7];
  assign io_soft_irq = msip_q & io_csr_mstatus[3] & io_csr_mie[3];

  assign unused_bits = ^{io.req_addr[2:0], io_csr_mstatus[63:4], io_csr_mstatus[2:0],
                         io_csr_mie[63:8], io_csr_mie[6:4], io_csr_mie[2:0]};

endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Directed bench for clint_irq_ctrl: one instance with TICK_DIV=1 for bus and
// interrupt behaviour, one with TICK_DIV=4 for prescaler and mtime wrap.
module tb_clint_irq_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] mstatus, mie;
  logic        time_irq_a, soft_irq_a, time_irq_b, soft_irq_b;
  logic [63:0] mtime_a, mtime_b;

  clint_irq_ctrl_if bus_a ();
  clint_irq_ctrl_if bus_b ();

  clint_irq_ctrl #(.TICK_DIV(1)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .io             (bus_a.slave),
    .io_csr_mstatus (mstatus),
    .io_csr_mie     (mie),
    .io_time_irq    (time_irq_a),
    .io_soft_irq    (soft_irq_a),
    .io_mtime       (mtime_a)
  );

  clint_irq_ctrl #(.TICK_DIV(4)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .io             (bus_b.slave),
    .io_csr_mstatus (mstatus),
    .io_csr_mie     (mie),
    .io_time_irq    (time_irq_b),
    .io_soft_irq    (soft_irq_b),
    .io_mtime       (mtime_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One bus transaction on instance A. Entered and left at a negedge; with
  // hold=0 it spans exactly two clocks.
  task automatic access(input string tag, input logic [15:0] addr, input logic wen,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        input logic [63:0] exp_rdata, input logic exp_err, input int hold);
    resp_t e;
    resp_t exp_q;
    int    n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    bus_a.resp_ready = (hold == 0);
    bus_a.req_addr   = addr;
    bus_a.req_wen    = wen;
    bus_a.req_wdata  = wdata;
    bus_a.req_wmask  = wmask;
    bus_a.req_valid  = 1'b1;
    n = 0;
    while (!bus_a.req_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    check_bit({tag, "/req_ready"}, bus_a.req_ready, 1'b1);
    @(negedge clock);
    bus_a.req_valid = 1'b0;
    n = 0;
    while (!bus_a.resp_valid && n < 8) begin
      @(negedge clock);
      n++;
    end
    check_bit({tag, "/resp_valid"}, bus_a.resp_valid, 1'b1);
    exp_q = sb.pop_front();
    check({tag, "/rdata"}, bus_a.resp_rdata, exp_q.rdata);
    check_bit({tag, "/err"}, bus_a.resp_err, exp_q.err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_bit({tag, "/hold_valid"}, bus_a.resp_valid, 1'b1);
      check_bit({tag, "/hold_req_ready"}, bus_a.req_ready, 1'b0);
      check({tag, "/hold_rdata"}, bus_a.resp_rdata, exp_q.rdata);
      check_bit({tag, "/hold_err"}, bus_a.resp_err, exp_q.err);
    end
    bus_a.resp_ready = 1'b1;
    @(negedge clock);
    check_bit({tag, "/done"}, bus_a.resp_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] exp_b;
    reset   = 1'b0;
    mstatus = 64'h8;
    mie     = 64'h88;
    bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_wen = 1'b0;
    bus_a.req_wdata = '0;   bus_a.req_wmask = '0; bus_a.resp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_wen = 1'b0;
    bus_b.req_wdata = '0;   bus_b.req_wmask = '0; bus_b.resp_ready = 1'b1;

    repeat (3) @(negedge clock);
    check_bit("rst_req_ready", bus_a.req_ready, 1'b1);
    check_bit("rst_resp_valid", bus_a.resp_valid, 1'b0);
    check("rst_rdata", bus_a.resp_rdata, 64'd0);
    check_bit("rst_err", bus_a.resp_err, 1'b0);
    check_bit("rst_time_irq", time_irq_a, 1'b0);
    check_bit("rst_soft_irq", soft_irq_a, 1'b0);
    check("rst_mtime", mtime_a, 64'd0);
    check("rst_mtime_b", mtime_b, 64'd0);

    // Release reset; instance B loads mtime near wrap on the first edge.
    reset = 1'b1;
    bus_b.req_addr  = 16'hBFF8;
    bus_b.req_wen   = 1'b1;
    bus_b.req_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
    bus_b.req_wmask = 8'hFF;
    bus_b.req_valid = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clock);
      if (e == 1) begin
        check_bit("b_wr_resp_valid", bus_b.resp_valid, 1'b1);
        bus_b.req_valid = 1'b0;
      end
      exp_b = (e < 4) ? 64'hFFFF_FFFF_FFFF_FFFE :
              (e < 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
      check("b_mtime", mtime_b, exp_b);
      check_bit("b_time_irq", time_irq_b, (e >= 4) && (e < 8));
    end
    @(negedge clock);
    check("idle10_mtime", mtime_a, 64'd10);
    check_bit("idle10_time_irq", time_irq_a, 1'b0);
    check_bit("idle10_soft_irq", soft_irq_a, 1'b0);

    access("rd_cmp_rst", 16'h4000, 1'b0, '0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);

    // Timer interrupt.
    access("wr_mtime4", 16'hBFF8, 1'b1, 64'd4, 8'hFF, 64'd0, 1'b0, 0);
    check("mtime_after_wr", mtime_a, 64'd5);
    access("wr_cmp20", 16'h4000, 1'b1, 64'd20, 8'hFF, 64'd0, 1'b0, 0);
    for (int k = 0; k < 16; k++) begin
      check("mtip_mtime", mtime_a, 64'(7 + k));
      check_bit("mtip_irq", time_irq_a, (7 + k) >= 20);
      @(negedge clock);
    end
    mstatus = 64'h0;
    #1 check_bit("mie_off_time_irq", time_irq_a, 1'b0);
    mstatus = 64'h8;
    #1 check_bit("mie_on_time_irq", time_irq_a, 1'b1);
    access("wr_cmp_max", 16'h4000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0, 0);
    check_bit("cmp_max_time_irq", time_irq_a, 1'b0);

    // Software interrupt.
    access("wr_msip", 16'h0000, 1'b1, 64'hFFFF_FFFF, 8'h01, 64'd0, 1'b0, 0);
    check_bit("msip_soft_irq", soft_irq_a, 1'b1);
    access("rd_msip_alias", 16'h0007, 1'b0, '0, 8'h00, 64'd1, 1'b0, 0);
    access("wr_msip_nomask", 16'h0000, 1'b1, 64'd0, 8'h00, 64'd0, 1'b0, 0);
    check_bit("nomask_soft_irq", soft_irq_a, 1'b1);
    access("wr_msip_clr", 16'h0000, 1'b1, 64'd0, 8'h01, 64'd0, 1'b0, 0);
    check_bit("clr_soft_irq", soft_irq_a, 1'b0);
    access("rd_msip", 16'h0000, 1'b0, '0, 8'h00, 64'd0, 1'b0, 0);

    // Unmapped offsets, with a stalled response.
    access("rd_unmapped", 16'h1234, 1'b0, '0, 8'h00, 64'd0, 1'b1, 3);
    access("wr_unmapped", 16'h8000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b1, 0);

    // Reset while a response is pending.
    bus_a.resp_ready = 1'b0;
    bus_a.req_addr   = 16'h4000;
    bus_a.req_wen    = 1'b0;
    bus_a.req_valid  = 1'b1;
    @(negedge clock);
    bus_a.req_valid = 1'b0;
    check_bit("midrst_pending", bus_a.resp_valid, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("midrst_resp_valid", bus_a.resp_valid, 1'b0);
    check_bit("midrst_req_ready", bus_a.req_ready, 1'b1);
    check("midrst_mtime", mtime_a, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_bit("postrst_no_stale", bus_a.resp_valid, 1'b0);
    check("postrst_mtime", mtime_a, 64'd1);

    access("wr_cmp_mask", 16'h4000, 1'b1, 64'h0000_0000_1234_5678, 8'h0F, 64'd0, 1'b0, 0);
    access("rd_cmp_mask", 16'h4000, 1'b0, '0, 8'h00, 64'hFFFF_FFFF_1234_5678, 1'b0, 0);
    check_bit("cmp_mask_time_irq", time_irq_a, 1'b0);
    access("rd_mtime", 16'hBFF8, 1'b0, '0, 8'h00, 64'd5, 1'b0, 0);
    access("wr_mtime_hi", 16'hBFF8, 1'b1, 64'h1_0000_0000, 8'hFF, 64'd0, 1'b0, 0);
    check("mtime_hi", mtime_a, 64'h1_0000_0001);

    check_bit("sb_empty", sb.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
